fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 114 +++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding memory read, holds the fetched word until decode accepts it.
// Optional jump predecode on accept is enabled by defining FETCH_JUMP_PREDECODE_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0028
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [31:0] mem_addr,
  output logic        mem_read,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        redir_valid,
  input  logic [31:0] redir_target,
  output logic [31:0] ins,
  output logic [31:0] ins_pc,
  output logic        ins_valid,
  input  logic        ins_ready,
  output logic [15:0] fetch_count
);

  typedef enum logic {StFetch, StHold} state_e;

  state_e      r_state;
  state_e      w_state_d;
  logic [31:0] r_pc;
  logic [31:0] w_pc_d;
  logic [31:0] r_ir;
  logic [31:0] r_ins_pc;
  logic [15:0] r_fetch_count;
  logic [31:0] w_next_pc;
  logic [31:0] w_accept_pc;
  logic        w_capture;
  logic        w_accept;

  // A redirect cancels both the memory ack and the decode handshake in the same cycle.
  assign w_capture = (r_state == StFetch) && mem_ack && !redir_valid;
  assign w_accept  = (r_state == StHold) && ins_ready && !redir_valid;
  assign w_next_pc = r_pc + 32'd4;

`ifdef FETCH_JUMP_PREDECODE_EN
  logic [31:0] w_ins_pc_plus4;
  assign w_ins_pc_plus4 = r_ins_pc + 32'd4;

  always_comb begin
    w_accept_pc = w_next_pc;
    if (r_ir[31:26] == 6'd2) begin
      w_accept_pc = {w_ins_pc_plus4[31:28], r_ir[25:0], 2'b00};
    end
  end
`else
  assign w_accept_pc = w_next_pc;
`endif

  always_comb begin
    w_pc_d = r_pc;
    if (redir_valid) begin
      w_pc_d = {redir_target[31:2], 2'b00};
    end else if (w_accept) begin
      w_pc_d = w_accept_pc;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= StFetch;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_d = r_state;
    if (redir_valid) begin
      w_state_d = StFetch;
    end else begin
      unique case (r_state)
        StFetch: if (mem_ack)   w_state_d = StHold;
        StHold:  if (ins_ready) w_state_d = StFetch;
        default: w_state_d = StFetch;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_pc          <= {RESET_PC[31:2], 2'b00};
      r_ir          <= 32'd0;
      r_ins_pc      <= 32'd0;
      r_fetch_count <= 16'd0;
    end else begin
      r_pc <= w_pc_d;
      if (w_capture) begin
        r_ir     <= mem_rdata;
        r_ins_pc <= r_pc;
      end
      if (w_accept) begin
        r_fetch_count <= r_fetch_count + 16'd1;
      end
    end
  end

  // Outputs; mem_read is masked while reset is asserted.
  always_comb begin
    mem_read    = reset_n && (r_state == StFetch);
    mem_addr    = r_pc;
    ins_valid   = (r_state == StHold);
    ins         = r_ir;
    ins_pc      = r_ins_pc;
    fetch_count = r_fetch_count;
  end

endmodule
